// File: rtl/train_seq_pkg.sv
// Shared definitions for the training-loop sequencer.
//   state_e  : FSM state encoding
//   layer_w  : derives the layer-index width from the layer count
package train_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_CHECK = 3'd2,
    ST_BWD   = 3'd3,
    ST_UPD   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // A single-layer network still needs a one-bit index.
  function automatic int layer_w(input int num_layers);
    int w;
    w = $clog2(num_layers);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/train_seq_ctrl_layer_idx_ctr.sv
// Loadable up/down layer index counter.
//   clk_i, rst_i : clock, async active-low reset
//   clr_i        : synchronous clear, ignores en_i
//   en_i         : enable for all other operations
//   ld_zero_i    : load 0
//   ld_max_i     : load MAX_VAL
//   inc_i/dec_i  : count up / down
//   cnt_o        : current index
// Priority: clr, ld_zero, ld_max, inc, dec.
module layer_idx_ctr #(
  parameter int W       = 1,
  parameter int MAX_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         ld_zero_i,
  input  logic         ld_max_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_L = W'(MAX_VAL);
  localparam logic [W-1:0] ONE_L = W'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      if (ld_zero_i) begin
        cnt_o <= '0;
      end else if (ld_max_i) begin
        cnt_o <= MAX_L;
      end else if (inc_i) begin
        cnt_o <= cnt_o + ONE_L;
      end else if (dec_i) begin
        cnt_o <= cnt_o - ONE_L;
      end
    end
  end

endmodule

// File: rtl/train_seq_ctrl.sv
// Training-loop sequencer: per-layer forward passes, loss check,
// reverse-order backward passes and a weight-update pulse, per epoch.
// Ends on loss convergence or on the epoch limit.
//   clk_i, rst_i      : clock, async active-low reset
//   en_i              : global enable (freezes everything when low)
//   start_i, abort_i  : run control; abort wins and ignores en_i
//   max_epochs_i      : epoch limit (0 = unlimited), sampled at start
//   loss_thresh_i     : convergence threshold, sampled at start
//   loss_i            : accumulated loss from the datapath
//   layer_done_i      : current layer pass complete
//   fwd_o, bwd_o      : pass direction active
//   layer_o           : active layer index
//   zero_loss_o       : pulse, clear loss accumulator
//   zero_final_o      : pulse, clear final-output registers
//   wupd_o            : pulse, commit weight updates
//   epoch_o           : weight updates completed this run
//   busy_o, done_o    : handshake status
//   converged_o       : run ended on loss <= threshold (valid in DONE)
//
// state | meaning
// IDLE  | waiting for start
// FWD   | forward pass, layer counts up
// CHECK | one cycle: convergence / epoch-limit decision
// BWD   | backward pass, layer counts down
// UPD   | one cycle: weight-update and clear pulses, epoch+1
// DONE  | run finished, status held until start or abort
module train_seq_ctrl
  import train_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int LAYER_W    = layer_w(NUM_LAYERS),
  parameter int EPOCH_W    = 8,
  parameter int LOSS_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [EPOCH_W-1:0] max_epochs_i,
  input  logic [LOSS_W-1:0]  loss_thresh_i,
  input  logic [LOSS_W-1:0]  loss_i,
  input  logic               layer_done_i,
  output logic               fwd_o,
  output logic               bwd_o,
  output logic [LAYER_W-1:0] layer_o,
  output logic               zero_loss_o,
  output logic               zero_final_o,
  output logic               wupd_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               converged_o
);

  localparam logic [LAYER_W-1:0] LAST_L = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [EPOCH_W-1:0] ONE_E  = EPOCH_W'(1);

  state_e              state_q, state_d;
  logic [EPOCH_W-1:0]  epoch_q, lim_q;
  logic [LOSS_W-1:0]   thr_q;
  logic                conv_q;
  logic [EPOCH_W-1:0]  epoch_nxt;

  logic lyr_clr, lyr_ld_zero, lyr_ld_max, lyr_inc, lyr_dec;
  logic ep_clr, ep_inc, cfg_ld, conv_set, conv_clr;
  logic zl_c, zf_c, wupd_c;

  assign epoch_nxt = epoch_q + ONE_E;

  always_comb begin
    state_d     = state_q;
    lyr_clr     = 1'b0;
    lyr_ld_zero = 1'b0;
    lyr_ld_max  = 1'b0;
    lyr_inc     = 1'b0;
    lyr_dec     = 1'b0;
    ep_clr      = 1'b0;
    ep_inc      = 1'b0;
    cfg_ld      = 1'b0;
    conv_set    = 1'b0;
    conv_clr    = 1'b0;
    zl_c        = 1'b0;
    zf_c        = 1'b0;
    wupd_c      = 1'b0;

    if (abort_i) begin
      state_d  = ST_IDLE;
      lyr_clr  = 1'b1;
      ep_clr   = 1'b1;
      conv_clr = 1'b1;
    end else if (en_i) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cfg_ld      = 1'b1;
            lyr_ld_zero = 1'b1;
            ep_clr      = 1'b1;
            conv_clr    = 1'b1;
            zl_c        = 1'b1;
            zf_c        = 1'b1;
            state_d     = ST_FWD;
          end
        end
        ST_FWD: begin
          if (layer_done_i) begin
            if (layer_o == LAST_L) state_d = ST_CHECK;
            else                   lyr_inc = 1'b1;
          end
        end
        ST_CHECK: begin
          if (loss_i <= thr_q) begin
            conv_set = 1'b1;
            state_d  = ST_DONE;
          end else if ((lim_q != '0) && (epoch_nxt == lim_q)) begin
            state_d = ST_DONE;
          end else begin
            lyr_ld_max = 1'b1;
            state_d    = ST_BWD;
          end
        end
        ST_BWD: begin
          if (layer_done_i) begin
            if (layer_o == '0) state_d = ST_UPD;
            else               lyr_dec = 1'b1;
          end
        end
        ST_UPD: begin
          wupd_c      = 1'b1;
          zl_c        = 1'b1;
          zf_c        = 1'b1;
          ep_inc      = 1'b1;
          lyr_ld_zero = 1'b1;
          state_d     = ST_FWD;
        end
        default: begin
          state_d = ST_IDLE;
          lyr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      epoch_q <= '0;
      lim_q   <= '0;
      thr_q   <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ep_clr)      epoch_q <= '0;
      else if (ep_inc) epoch_q <= epoch_nxt;
      if (cfg_ld) begin
        lim_q <= max_epochs_i;
        thr_q <= loss_thresh_i;
      end
      if (conv_clr)      conv_q <= 1'b0;
      else if (conv_set) conv_q <= 1'b1;
    end
  end

  layer_idx_ctr #(
    .W       (LAYER_W),
    .MAX_VAL (NUM_LAYERS - 1)
  ) u_layer_idx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .clr_i     (lyr_clr),
    .ld_zero_i (lyr_ld_zero),
    .ld_max_i  (lyr_ld_max),
    .inc_i     (lyr_inc),
    .dec_i     (lyr_dec),
    .cnt_o     (layer_o)
  );

  assign fwd_o       = (state_q == ST_FWD);
  assign bwd_o       = (state_q == ST_BWD);
  assign busy_o      = (state_q == ST_FWD) || (state_q == ST_CHECK) ||
                       (state_q == ST_BWD) || (state_q == ST_UPD);
  assign done_o      = (state_q == ST_DONE);
  assign epoch_o     = epoch_q;
  assign converged_o = conv_q;

  // Gate with reset so a start_i seen while in reset cannot leak a pulse.
  assign zero_loss_o  = zl_c   & rst_i;
  assign zero_final_o = zf_c   & rst_i;
  assign wupd_o       = wupd_c & rst_i;

endmodule

// File: tb/tb_train_seq_ctrl.sv
module tb_train_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       start_i;
  logic       abort_i;
  logic [7:0] max_epochs_i;
  logic [7:0] loss_thresh_i;
  logic [7:0] loss_i;
  logic       layer_done_i;
  logic       fwd_o, bwd_o;
  logic [1:0] layer_o;
  logic       zero_loss_o, zero_final_o, wupd_o;
  logic [7:0] epoch_o;
  logic       busy_o, done_o, converged_o;

  int errors = 0;
  int checks = 0;
  int n_wupd = 0;
  int n_zl   = 0;
  int w0, z0;

  train_seq_ctrl #(
    .NUM_LAYERS (3),
    .LAYER_W    (2),
    .EPOCH_W    (8),
    .LOSS_W     (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .max_epochs_i  (max_epochs_i),
    .loss_thresh_i (loss_thresh_i),
    .loss_i        (loss_i),
    .layer_done_i  (layer_done_i),
    .fwd_o         (fwd_o),
    .bwd_o         (bwd_o),
    .layer_o       (layer_o),
    .zero_loss_o   (zero_loss_o),
    .zero_final_o  (zero_final_o),
    .wupd_o        (wupd_o),
    .epoch_o       (epoch_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .converged_o   (converged_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulses are already gated by en_i, so every high sample at an edge is one event.
  always @(posedge clk_i) begin
    if (wupd_o)      n_wupd++;
    if (zero_loss_o) n_zl++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; leaves at the negedge after the start edge.
  task automatic do_start(input string tag, input logic [7:0] lim,
                          input logic [7:0] thr, input logic [7:0] loss);
    max_epochs_i  = lim;
    loss_thresh_i = thr;
    loss_i        = loss;
    start_i       = 1'b1;
    #1;
    chk({tag, "_start_zl"}, zero_loss_o, 1);
    chk({tag, "_start_zf"}, zero_final_o, 1);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    chk({tag, "_start_fwd"}, fwd_o, 1);
    chk({tag, "_start_layer"}, layer_o, 0);
    chk({tag, "_start_epoch"}, epoch_o, 0);
    chk({tag, "_start_conv"}, converged_o, 0);
  endtask

  task automatic fwd_pass(input string tag);
    for (int l = 0; l < 3; l++) begin
      layer_done_i = 1'b1;
      #1;
      chk({tag, "_fwd"}, fwd_o, 1);
      chk({tag, "_fwd_layer"}, layer_o, l);
      @(negedge clk_i);
    end
    layer_done_i = 1'b0;
  endtask

  task automatic check_step(input string tag);
    #1;
    chk({tag, "_check_busy"}, busy_o, 1);
    chk({tag, "_check_dir"}, {fwd_o, bwd_o}, 0);
    @(negedge clk_i);
  endtask

  task automatic bwd_pass(input string tag);
    for (int l = 2; l >= 0; l--) begin
      layer_done_i = 1'b1;
      #1;
      chk({tag, "_bwd"}, bwd_o, 1);
      chk({tag, "_bwd_layer"}, layer_o, l);
      @(negedge clk_i);
    end
    layer_done_i = 1'b0;
  endtask

  task automatic upd_step(input string tag, input int e);
    #1;
    chk({tag, "_upd_wupd"}, wupd_o, 1);
    chk({tag, "_upd_zl"}, zero_loss_o, 1);
    chk({tag, "_upd_zf"}, zero_final_o, 1);
    chk({tag, "_upd_epoch_pre"}, epoch_o, e);
    @(negedge clk_i);
    #1;
    chk({tag, "_upd_epoch_post"}, epoch_o, (e + 1) % 256);
  endtask

  initial begin
    rst_i = 1'b0; en_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    max_epochs_i = '0; loss_thresh_i = '0; loss_i = '0; layer_done_i = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_layer", layer_o, 0);
    chk("rst_epoch", epoch_o, 0);
    chk("rst_pulses", {zero_loss_o, zero_final_o, wupd_o, converged_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Epoch limit 3: two full epochs then a third FWD+CHECK
    w0 = n_wupd;
    do_start("lim", 8'd3, 8'd0, 8'd50);
    for (int e = 0; e < 2; e++) begin
      fwd_pass("lim");
      check_step("lim");
      bwd_pass("lim");
      upd_step("lim", e);
    end
    fwd_pass("lim");
    check_step("lim");
    #1;
    chk("lim_done", done_o, 1);
    chk("lim_busy", busy_o, 0);
    chk("lim_conv", converged_o, 0);
    chk("lim_epoch", epoch_o, 2);
    chk("lim_wupd_cnt", n_wupd - w0, 2);

    // Convergence at the first CHECK
    @(negedge clk_i);
    w0 = n_wupd;
    do_start("cvg", 8'd3, 8'd10, 8'd5);
    fwd_pass("cvg");
    check_step("cvg");
    #1;
    chk("cvg_done", done_o, 1);
    chk("cvg_conv", converged_o, 1);
    chk("cvg_epoch", epoch_o, 0);
    chk("cvg_wupd_cnt", n_wupd - w0, 0);

    // Restart from DONE, then reset mid-FWD at layer 2
    @(negedge clk_i);
    z0 = n_zl;
    do_start("rs", 8'd0, 8'd0, 8'd50);
    layer_done_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    layer_done_i = 1'b0;
    #1;
    chk("rs_layer2", layer_o, 2);
    chk("rs_zl_once", n_zl - z0, 1);
    start_i = 1'b1;
    #1;
    chk("rs_busy_start_ignored", zero_loss_o, 0);
    rst_i = 1'b0;
    #1;
    chk("rs_reset_state", {fwd_o, bwd_o, busy_o, done_o, converged_o}, 0);
    chk("rs_reset_layer", layer_o, 0);
    chk("rs_reset_pulses", {zero_loss_o, zero_final_o, wupd_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b0;

    // Abort at BWD layer 1 in epoch 1, with en_i low
    @(negedge clk_i);
    do_start("ab", 8'd0, 8'd0, 8'd50);
    fwd_pass("ab");
    check_step("ab");
    bwd_pass("ab");
    upd_step("ab", 0);
    fwd_pass("ab");
    check_step("ab");
    layer_done_i = 1'b1;
    @(negedge clk_i);
    layer_done_i = 1'b0;
    #1;
    chk("ab_at_bwd1", {bwd_o, layer_o}, 3'b101);
    en_i = 1'b0; abort_i = 1'b1;
    #1;
    chk("ab_pulses", {zero_loss_o, zero_final_o, wupd_o}, 0);
    @(negedge clk_i);
    abort_i = 1'b0; en_i = 1'b1;
    #1;
    chk("ab_idle", {busy_o, done_o, fwd_o, bwd_o}, 0);
    chk("ab_layer", layer_o, 0);
    chk("ab_epoch", epoch_o, 0);

    // en_i low for 5 cycles while in UPD
    @(negedge clk_i);
    do_start("en", 8'd0, 8'd0, 8'd50);
    fwd_pass("en");
    check_step("en");
    bwd_pass("en");
    w0 = n_wupd;
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("en_hold_wupd", wupd_o, 0);
      chk("en_hold_epoch", epoch_o, 0);
      chk("en_hold_busy", {busy_o, fwd_o, bwd_o}, 3'b100);
      @(negedge clk_i);
    end
    en_i = 1'b1;
    #1;
    chk("en_wupd_fire", wupd_o, 1);
    @(negedge clk_i);
    #1;
    chk("en_epoch_inc", epoch_o, 1);
    chk("en_wupd_cnt", n_wupd - w0, 1);
    chk("en_back_fwd", fwd_o, 1);

    // Unlimited run: 299 more epochs, epoch counter wraps to 44
    w0 = n_wupd;
    start_i = 1'b1;
    #1;
    chk("wrap_busy_start_ignored", zero_loss_o, 0);
    layer_done_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (299 * 8 - 1) @(negedge clk_i);
    layer_done_i = 1'b0;
    #1;
    chk("wrap_busy", busy_o, 1);
    chk("wrap_fwd_layer0", {fwd_o, layer_o}, 3'b100);
    chk("wrap_epoch", epoch_o, 44);
    chk("wrap_wupd_cnt", n_wupd - w0, 299);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/train_seq_ctrl.md
# train_seq_ctrl

Parametrised training-loop sequencer for the on-chip learner. It steps a network of `NUM_LAYERS` layers through per-layer forward passes, a loss check, reverse-order backward passes and a weight-update pulse, repeating per epoch. It terminates on loss convergence or on an epoch limit. It sits between the top-level control pins and the layer datapath, and replaces the fixed two-forward/one-backward sequencer with layer indexing, epoch counting, convergence detection, abort and a busy/done handshake.

## Interface
- `NUM_LAYERS`, default 2: number of layers sequenced; must be ≥1.
- `LAYER_W`, default `max(1,$clog2(NUM_LAYERS))`: width of the layer index.
- `EPOCH_W`, default 8: width of the epoch counter and limit.
- `LOSS_W`, default 8: width of the unsigned loss and threshold.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  global enable; when low, state, counters and pulses freeze.
- `start_i`  in  1  starts a run from IDLE or DONE.
- `abort_i`  in  1  forces IDLE from any state.
- `max_epochs_i`  in  `EPOCH_W`  epoch limit, sampled at start; 0 means unlimited.
- `loss_thresh_i`  in  `LOSS_W`  convergence threshold, sampled at start.
- `loss_i`  in  `LOSS_W`  current accumulated loss from the datapath.
- `layer_done_i`  in  1  the current layer's pass has completed.
- `fwd_o`  out  1  forward pass active.
- `bwd_o`  out  1  backward pass active.
- `layer_o`  out  `LAYER_W`  index of the active layer.
- `zero_loss_o`  out  1  one-cycle pulse: clear the loss accumulator.
- `zero_final_o`  out  1  one-cycle pulse: clear the final-output registers.
- `wupd_o`  out  1  one-cycle pulse: commit weight updates.
- `epoch_o`  out  `EPOCH_W`  completed weight updates this run.
- `busy_o`  out  1  high in FWD, CHECK, BWD and UPD.
- `done_o`  out  1  high in DONE.
- `converged_o`  out  1  valid in DONE: the run ended because loss was at or below threshold.

## Operation
- States: IDLE, FWD, CHECK, BWD, UPD, DONE.
- Reset values: state IDLE, layer 0, epoch 0, all outputs 0.
- IDLE / DONE:
  - On `start_i`, latch the limit and threshold, clear layer, epoch and `converged_o`, pulse `zero_loss_o` and `zero_final_o`, then go to FWD.
  - DONE holds `done_o` and `converged_o` until start or abort.
- FWD:
  - `fwd_o`=1.
  - On `layer_done_i`: if layer==`NUM_LAYERS`-1, go to CHECK; otherwise layer+1.
- CHECK (one cycle), with priority:
  - `loss_i` ≤ threshold: DONE with `converged_o`=1.
  - Else limit≠0 and epoch+1==limit: DONE with `converged_o`=0.
  - Else: go to BWD with layer=`NUM_LAYERS`-1.
- BWD:
  - `bwd_o`=1.
  - On `layer_done_i`: if layer==0, go to UPD; otherwise layer−1.
- UPD (one cycle):
  - Pulse `wupd_o`, `zero_loss_o` and `zero_final_o`.
  - epoch+1, wrapping at 2^`EPOCH_W` (possible only when the limit is 0).
  - Layer to 0, then FWD.
- `abort_i` is highest priority and ignores `en_i`: next state IDLE, layer and epoch cleared, no pulses.
- `layer_done_i` outside FWD/BWD is ignored. `start_i` while busy is ignored.
- `NUM_LAYERS`==1: the layer index stays 0; FWD and BWD each need one `layer_done_i`.

## Timing
- All state, counter and pulse updates occur on the `clk_i` edge where `en_i`=1. With `en_i`=0, everything holds and the pulse outputs are 0.
- `fwd_o`, `bwd_o`, `layer_o`, `busy_o`, `done_o` and `epoch_o` decode from registered state; no combinational path from inputs.
- Pulses are Mealy, gated by `en_i`: start pulses are asserted in the cycle `start_i` is seen; UPD pulses are asserted during the UPD cycle. Exactly one of each per event.
- `layer_done_i` is sampled each enabled cycle, and `layer_o` changes on the following edge. Back-to-back `layer_done_i` advances one layer per cycle.
- Epoch latency with L layers and a one-cycle done from each layer: L (FWD) + 1 (CHECK) + L (BWD) + 1 (UPD) cycles.
- Asynchronous reset mid-run returns to IDLE immediately; pulses deassert combinationally.

## Structure
- Package `train_seq_pkg`: state enum (3-bit: IDLE=0, FWD=1, CHECK=2, BWD=3, UPD=4, DONE=5) and the `LAYER_W` derivation function.
- One sub-module, `layer_idx_ctr`: a loadable up/down counter for `layer_o` with load-zero and load-max inputs. The FSM, epoch counter and compare stay in the top module.

## Test plan
- `NUM_LAYERS`=3, limit 3, threshold 0, `loss_i`=50, single-cycle dones:
  - Layers run 0,1,2 | CHECK | 2,1,0 | UPD, twice, then a third FWD and CHECK.
  - Ends in DONE with `epoch_o`=2, `converged_o`=0 and exactly 2 `wupd_o` pulses.
- Threshold 10, `loss_i`=5 at the first CHECK:
  - DONE after 3 forward dones, `converged_o`=1, `epoch_o`=0, no `wupd_o`.
- `abort_i` at BWD layer 1, asserted with `en_i`=0:
  - Next cycle in IDLE, `layer_o`=0, `epoch_o`=0, no pulses.
- Hold `en_i`=0 for 5 cycles while in UPD:
  - `wupd_o` stays 0 throughout; the pulse fires once when enabled; `epoch_o` increments by exactly 1.
- Limit 0, loss held high:
  - After 300 epochs still busy with `epoch_o`=44, showing wrap at 2^8.
- Assert reset mid-FWD at layer 2, then `start_i` from DONE:
  - All outputs 0 immediately on reset.
  - A restart from DONE clears `converged_o` and pulses `zero_loss_o` and `zero_final_o` once.
